ssm_tile_sched: RTL and testbench

//  Sequencer in front of SSMBLOCK_TOP. Walks num_groups_i (h,p) groups x TILES_PER_GROUP N-tiles.

---
 rtl/ssm_pkg.sv | 26 ++
 rtl/ssm_tile_sched_if.sv | 38 +++
 rtl/ssm_valid_delay.sv | 56 +++++
 rtl/ssm_tile_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ssm_tile_sched.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssm_pkg
// Brief    : Shared types and defaults for the SSM tile scheduler: FSM state
//            encoding, N_TILE/N_TOTAL defaults and the tiles-per-group helper.
// Revision : 1.0 - initial release
// ============================================================================
package ssm_pkg;

  localparam int N_TILE_DEF  = 64;
  localparam int N_TOTAL_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Number of N-tiles needed to cover one (h,p) group: ceil(n_total / n_tile).
  function automatic int tiles_per_group(input int n_total, input int n_tile);
    return (n_total + n_tile - 1) / n_tile;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssm_tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ssm_tile_sched_if
// Brief    : Control, tile-memory read and SSMBLOCK_TOP strobe bundle of the
//            tile scheduler. "master" is the scheduler view, "slave" the
//            environment (job controller, tile memory, SSM block) view.
// Revision : 1.0 - initial release
// ============================================================================
interface ssm_tile_sched_if #(
  parameter int GW = 12,
  parameter int AW = 16
);

  logic          start_i;
  logic [GW-1:0] num_groups_i;
  logic          busy_o;
  logic          done_o;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic          tile_valid_o;
  logic          tile_last_o;
  logic          y_valid_i;
  logic          err_o;

  modport master (
    input  start_i, num_groups_i, y_valid_i,
    output busy_o, done_o, mem_rd_en_o, mem_rd_addr_o,
           tile_valid_o, tile_last_o, err_o
  );

  modport slave (
    output start_i, num_groups_i, y_valid_i,
    input  busy_o, done_o, mem_rd_en_o, mem_rd_addr_o,
           tile_valid_o, tile_last_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/ssm_valid_delay.sv
`default_nettype none
// ============================================================================
// Module   : ssm_valid_delay
// Brief    : RD_LAT-deep {en,last} shift register that lines the tile_valid
//            strobe up with tile-memory read data. empty_o is high when no
//            read is still travelling through the line.
// Revision : 1.0 - initial release
// ============================================================================
module ssm_valid_delay #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  input  logic last_i,
  output logic en_o,
  output logic last_o,
  output logic empty_o
);

  logic [RD_LAT-1:0] en_q, en_d;
  logic [RD_LAT-1:0] last_q, last_d;

  generate
    if (RD_LAT == 1) begin : g_single
      // Single stage: the line is just one register.
      always_comb begin
        en_d   = en_i;
        last_d = last_i;
      end
    end else begin : g_chain
      // Shift the new read in at bit 0; the oldest entry leaves at the top.
      always_comb begin
        en_d   = {en_q[RD_LAT-2:0], en_i};
        last_d = {last_q[RD_LAT-2:0], last_i};
      end
    end
  endgenerate

  // Stage registers; reset drops any reads still in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= '0;
      last_q <= '0;
    end else begin
      en_q   <= en_d;
      last_q <= last_d;
    end
  end

  assign en_o    = en_q[RD_LAT-1];
  assign last_o  = last_q[RD_LAT-1];
  assign empty_o = ~|en_q;

endmodule
`default_nettype wire

// File: rtl/ssm_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : ssm_tile_sched
// Brief    : Sequencer in front of SSMBLOCK_TOP. Walks num_groups x
//            TILES_PER_GROUP tiles, issues one tile-memory read per cycle and
//            a tile_valid strobe aligned to the read data. A group credit
//            counter fed by y_valid_i throttles group starts because the
//            datapath has no backpressure.
//            Optional macro SSM_SCHED_PERF_EN adds perf_cycles_o and
//            perf_stall_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module ssm_tile_sched
  import ssm_pkg::*;
#(
  parameter int N_TILE       = N_TILE_DEF,
  parameter int N_TOTAL      = N_TOTAL_DEF,
  parameter int GW           = 12,
  parameter int AW           = 16,
  parameter int RD_LAT       = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  ssm_tile_sched_if.master     bus
`ifdef SSM_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int TPG = tiles_per_group(N_TOTAL, N_TILE);
  localparam int TW  = (TPG > 1) ? $clog2(TPG) : 1;
  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [TW-1:0] LAST_TILE  = TW'(TPG - 1);
  localparam logic [IW-1:0] MAX_CREDIT = IW'(MAX_INFLIGHT);

  sched_state_e  state_q, state_d;
  logic [GW-1:0] num_groups_q, num_groups_d;
  logic [GW-1:0] group_idx_q, group_idx_d;
  logic [TW-1:0] tile_idx_q, tile_idx_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic start_ok;
  logic group_start;
  logic stall;
  logic rd_en;
  logic last_tile;
  logic last_group;
  logic credit_inc;
  logic credit_dec;
  logic dly_empty;
  logic dly_valid;
  logic dly_last;

  // Issue qualification: only the first tile of a group waits for credit.
  always_comb begin
    start_ok    = (state_q == IDLE) && bus.start_i;
    group_start = (tile_idx_q == '0);
    stall       = (state_q == ISSUE) && group_start && (inflight_q == MAX_CREDIT);
    rd_en       = (state_q == ISSUE) && !stall;
    last_tile   = (tile_idx_q == LAST_TILE);
    last_group  = (group_idx_q == num_groups_q - GW'(1));
    credit_inc  = rd_en && group_start;
    credit_dec  = bus.y_valid_i && (inflight_q != '0);
  end

  // Next-state, tile/group walk, credit and error flag.
  always_comb begin
    state_d      = state_q;
    num_groups_d = num_groups_q;
    group_idx_d  = group_idx_q;
    tile_idx_d   = tile_idx_q;
    done_d       = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          num_groups_d = bus.num_groups_i;
          group_idx_d  = '0;
          tile_idx_d   = '0;
          state_d      = (bus.num_groups_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (rd_en) begin
          if (last_tile) begin
            tile_idx_d = '0;
            if (last_group) begin
              state_d = DRAIN;
            end else begin
              group_idx_d = group_idx_q + GW'(1);
            end
          end else begin
            tile_idx_d = tile_idx_q + TW'(1);
          end
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && dly_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Simultaneous issue and answer cancel; stall guarantees no overflow.
    inflight_d = inflight_q + IW'(credit_inc) - IW'(credit_dec);

    if (start_ok) begin
      err_d = 1'b0;
    end
    // An answer with nothing outstanding is a protocol error.
    if (bus.y_valid_i && (inflight_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      num_groups_q <= '0;
      group_idx_q  <= '0;
      tile_idx_q   <= '0;
      inflight_q   <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_groups_q <= num_groups_d;
      group_idx_q  <= group_idx_d;
      tile_idx_q   <= tile_idx_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  ssm_valid_delay #(
    .RD_LAT (RD_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (rd_en),
    .last_i  (rd_en && last_tile),
    .en_o    (dly_valid),
    .last_o  (dly_last),
    .empty_o (dly_empty)
  );

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.mem_rd_en_o   = rd_en;
  assign bus.mem_rd_addr_o = rd_en ? (AW'(group_idx_q) * AW'(TPG) + AW'(tile_idx_q)) : '0;
  assign bus.tile_valid_o  = dly_valid;
  assign bus.tile_last_o   = dly_last;

`ifdef SSM_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Busy and credit-stall cycle counters: clear on start, saturate at all-ones.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (start_ok) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if ((state_q != IDLE) && (perf_cycles_q != '1)) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssm_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssm_tile_sched
// Brief    : Directed self-checking bench for ssm_tile_sched (TPG=2,
//            RD_LAT=2, MAX_INFLIGHT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssm_tile_sched;

  localparam int GW     = 12;
  localparam int AW     = 16;
  localparam int RD_LAT = 2;
  localparam int TPG    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  ssm_tile_sched_if #(.GW(GW), .AW(AW)) bus ();

`ifdef SSM_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  ssm_tile_sched #(
    .N_TILE       (64),
    .N_TOTAL      (128),
    .GW           (GW),
    .AW           (AW),
    .RD_LAT       (RD_LAT),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef SSM_SCHED_PERF_EN
    ,
    .perf_cycles_o (perf_cycles),
    .perf_stall_o  (perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  int cyc       = 0;
  int rd_cnt    = 0;
  int tv_cnt    = 0;
  int done_cnt  = 0;
  int align_bad = 0;
  int addr_q[$];
  int rdcyc_q[$];
  int last_q[$];
  logic [RD_LAT-1:0] en_hist   = '0;
  logic [RD_LAT-1:0] last_hist = '0;

  // Observer: logs reads/strobes and checks tile_valid/last against a delayed model.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      en_hist   = '0;
      last_hist = '0;
    end else begin
      if ((bus.tile_valid_o !== en_hist[RD_LAT-1]) || (bus.tile_last_o !== last_hist[RD_LAT-1]))
        align_bad++;
      en_hist   = {en_hist[RD_LAT-2:0], bus.mem_rd_en_o};
      last_hist = {last_hist[RD_LAT-2:0],
                   bus.mem_rd_en_o && ((int'(bus.mem_rd_addr_o) % TPG) == TPG - 1)};
      if (bus.mem_rd_en_o === 1'b1) begin
        rd_cnt++;
        addr_q.push_back(int'(bus.mem_rd_addr_o));
        rdcyc_q.push_back(cyc);
      end
      if (bus.tile_valid_o === 1'b1) begin
        tv_cnt++;
        last_q.push_back(int'(bus.tile_last_o));
      end
      if (bus.done_o === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_cnt    = 0;
    tv_cnt    = 0;
    done_cnt  = 0;
    align_bad = 0;
    addr_q.delete();
    rdcyc_q.delete();
    last_q.delete();
  endtask

  task automatic pulse_y();
    bus.y_valid_i = 1'b1;
    tick(1);
    bus.y_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while ((done_cnt == 0) && (i < budget)) begin
      tick(1);
      i++;
    end
    check(tag, 32'(done_cnt != 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.num_groups_i = '0;
    bus.y_valid_i    = 1'b0;
    tick(3);

    // Reset state
    check("rst_busy",  32'(bus.busy_o),        32'd0);
    check("rst_done",  32'(bus.done_o),        32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en_o),   32'd0);
    check("rst_addr",  32'(bus.mem_rd_addr_o), 32'd0);
    check("rst_tv",    32'(bus.tile_valid_o),  32'd0);
    check("rst_tl",    32'(bus.tile_last_o),   32'd0);
    check("rst_err",   32'(bus.err_o),         32'd0);
    rstn = 1'b1;
    tick(2);

    // Three groups, plus a start pulse while busy that must be ignored
    clear_logs();
    bus.num_groups_i = 12'd3;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    bus.num_groups_i = '0;
    check("g3_busy",  32'(bus.busy_o),        32'd1);
    check("g3_rd0",   32'(bus.mem_rd_en_o),   32'd1);
    check("g3_addr0", 32'(bus.mem_rd_addr_o), 32'd0);
    tick(2);
    bus.num_groups_i = 12'd7;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    tick(38);
    pulse_y();
    tick(1);
    pulse_y();
    tick(1);
    check("g3_no_early_done", 32'(done_cnt), 32'd0);
    check("g3_busy_wait",     32'(bus.busy_o), 32'd1);
    pulse_y();
    wait_done("g3_done_seen", 20);
    check("g3_rd_cnt", 32'(rd_cnt), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("g3_addr%0d", i), 32'(addr_q[i]), 32'(i));
      check($sformatf("g3_last%0d", i), 32'(last_q[i]), 32'(i % 2));
    end
    check("g3_consecutive", 32'(rdcyc_q[5] - rdcyc_q[0]), 32'd5);
    check("g3_tv_cnt",      32'(tv_cnt),    32'd6);
    check("g3_align",       32'(align_bad), 32'd0);
    tick(3);
    check("g3_done_once", 32'(done_cnt),   32'd1);
    check("g3_idle",      32'(bus.busy_o), 32'd0);
    check("g3_err",       32'(bus.err_o),  32'd0);

    // Credit throttle: 10 groups with answers withheld
    clear_logs();
    bus.num_groups_i = 12'd10;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    tick(30);
    check("cr_rd_cnt8",  32'(rd_cnt),          32'd8);
    check("cr_addr7",    32'(addr_q[7]),       32'd7);
    check("cr_stalled",  32'(bus.mem_rd_en_o), 32'd0);
    check("cr_busy",     32'(bus.busy_o),      32'd1);
    // Answer arrives in a stalled group-start cycle: still stalled now, issue next
    bus.y_valid_i = 1'b1;
    check("cr_coinc_stall", 32'(bus.mem_rd_en_o), 32'd0);
    tick(1);
    bus.y_valid_i = 1'b0;
    check("cr_next_rd",    32'(bus.mem_rd_en_o),   32'd1);
    check("cr_next_addr8", 32'(bus.mem_rd_addr_o), 32'd8);
    tick(1);
    check("cr_addr9",      32'(bus.mem_rd_addr_o), 32'd9);
    tick(1);
    check("cr_stall_again", 32'(bus.mem_rd_en_o), 32'd0);
    tick(10);
    check("cr_rd_cnt10", 32'(rd_cnt), 32'd10);
    repeat (9) begin
      pulse_y();
      tick(3);
    end
    wait_done("cr_done_seen", 50);
    check("cr_rd_cnt20", 32'(rd_cnt),     32'd20);
    check("cr_addr19",   32'(addr_q[19]), 32'd19);
    check("cr_tv_cnt",   32'(tv_cnt),     32'd20);
    check("cr_align",    32'(align_bad),  32'd0);
    check("cr_err",      32'(bus.err_o),  32'd0);
    tick(2);

    // Empty job
    clear_logs();
    bus.num_groups_i = '0;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    check("e0_busy1", 32'(bus.busy_o), 32'd1);
    check("e0_done0", 32'(bus.done_o), 32'd0);
    tick(1);
    check("e0_busy2", 32'(bus.busy_o), 32'd0);
    check("e0_done1", 32'(bus.done_o), 32'd1);
    tick(1);
    check("e0_done_pulse", 32'(bus.done_o), 32'd0);
    check("e0_no_reads",   32'(rd_cnt),     32'd0);
    check("e0_done_cnt",   32'(done_cnt),   32'd1);

    // Spurious answer while idle sets the sticky error; start clears it
    pulse_y();
    check("err_set", 32'(bus.err_o), 32'd1);
    tick(2);
    check("err_sticky", 32'(bus.err_o), 32'd1);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    check("err_clr_start", 32'(bus.err_o), 32'd0);
    tick(3);

    // Reset in the middle of issuing with reads in the delay line
    clear_logs();
    bus.num_groups_i = 12'd5;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    tick(2);
    check("mr_reading", 32'(bus.mem_rd_en_o), 32'd1);
    rstn = 1'b0;
    tick(1);
    check("mr_busy",  32'(bus.busy_o),       32'd0);
    check("mr_rd_en", 32'(bus.mem_rd_en_o),  32'd0);
    check("mr_tv",    32'(bus.tile_valid_o), 32'd0);
    check("mr_tl",    32'(bus.tile_last_o),  32'd0);
    check("mr_done",  32'(bus.done_o),       32'd0);
    check("mr_err",   32'(bus.err_o),        32'd0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    clear_logs();
    bus.num_groups_i = 12'd1;
    bus.start_i      = 1'b1;
    tick(1);
    bus.start_i      = 1'b0;
    tick(5);
    pulse_y();
    wait_done("mr_done_seen", 20);
    check("mr_rd_cnt", 32'(rd_cnt),    32'd2);
    check("mr_addr0",  32'(addr_q[0]), 32'd0);
    check("mr_addr1",  32'(addr_q[1]), 32'd1);
    check("mr_tv_cnt", 32'(tv_cnt),    32'd2);
    check("mr_align",  32'(align_bad), 32'd0);
    check("mr_err2",   32'(bus.err_o), 32'd0);
    tick(2);
    check("mr_done_cnt", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
